// File: rtl/lbm_pkg.sv
// Shared types and helpers for the D2Q9 lattice-Boltzmann pipeline.
// Lid momentum correction is enabled by defining LBM_LID_CORR_EN.
package lbm_pkg;

  localparam int DIST_W = 16;

  typedef logic signed [DIST_W-1:0] dist_t;
  typedef dist_t [8:0] dist_vec_t;

  typedef enum logic [3:0] {
    D_REST = 4'd0,
    D_PY   = 4'd1,
    D_PX   = 4'd2,
    D_NY   = 4'd3,
    D_NX   = 4'd4,
    D_PYPX = 4'd5,
    D_NYPX = 4'd6,
    D_NYNX = 4'd7,
    D_PYNX = 4'd8
  } dir_e;

  localparam dir_e OPP [9] = '{
    D_REST, D_NY, D_NX, D_PY, D_PX,
    D_NYNX, D_PYNX, D_PYPX, D_NYPX
  };

  typedef enum logic [1:0] {
    WALL_RIGHT  = 2'd0,
    WALL_LEFT   = 2'd1,
    WALL_BOTTOM = 2'd2,
    WALL_LID    = 2'd3
  } wall_e;

  // Sum at DIST_W+1 bits, clamp to the signed DIST_W range.
  function automatic dist_t sat_add(
    input dist_t                 a,
    input logic signed [DIST_W:0] b
  );
    logic signed [DIST_W:0] s;
    s = a + b;
    if (s[DIST_W] != s[DIST_W-1]) begin
      sat_add = s[DIST_W] ? {1'b1, {(DIST_W-1){1'b0}}}
                          : {1'b0, {(DIST_W-1){1'b1}}};
    end else begin
      sat_add = s[DIST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/wall_detector.sv
// Classifies a cavity node into {LID, BOTTOM, LEFT, RIGHT}.
// Bottom wins corners, then the side walls, then the lid.
module wall_detector
  import lbm_pkg::*;
#(
  parameter int GRID_DIM = 256,
  parameter int X_W      = $clog2(GRID_DIM),
  parameter int Y_W      = $clog2(GRID_DIM/16)
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [3:0]     wall
);

  localparam int LAST = GRID_DIM/16 - 1;

  always_comb begin
    wall = '0;
    if (x == X_W'(0)) begin
      wall[WALL_BOTTOM] = 1'b1;
    end else if (y == Y_W'(0)) begin
      wall[WALL_LEFT] = 1'b1;
    end else if (y == Y_W'(LAST)) begin
      wall[WALL_RIGHT] = 1'b1;
    end else if (x == X_W'(LAST)) begin
      wall[WALL_LID] = 1'b1;
    end
  end

endmodule

// File: rtl/lbm_boundary_stage.sv
// Two-stage D2Q9 boundary stage: bounce-back on walls, moving lid.
// Define LBM_LID_CORR_EN to apply the saturated lid momentum term.
module lbm_boundary_stage
  import lbm_pkg::*;
#(
  parameter int GRID_DIM = 256,
  parameter int X_W      = $clog2(GRID_DIM),
  parameter int Y_W      = $clog2(GRID_DIM/16),
  parameter int DIST_W   = 16,
  parameter logic signed [DIST_W-1:0] LID_CORR = 16'sd85
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  input  dist_vec_t      in_f,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output dist_vec_t      out_f,
  output logic [3:0]     out_wall,
  output logic           frame_done
);

  localparam int LAST = GRID_DIM/16 - 1;

  logic [3:0] wall_c;

  wall_detector #(
    .GRID_DIM (GRID_DIM),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_wall (
    .x    (in_x),
    .y    (in_y),
    .wall (wall_c)
  );

  logic           s1_valid_q, s1_valid_d;
  logic [X_W-1:0] s1_x_q, s1_x_d;
  logic [Y_W-1:0] s1_y_q, s1_y_d;
  dist_vec_t      s1_f_q, s1_f_d;
  logic [3:0]     s1_wall_q, s1_wall_d;

  logic           s2_valid_q, s2_valid_d;
  logic [X_W-1:0] s2_x_q, s2_x_d;
  logic [Y_W-1:0] s2_y_q, s2_y_d;
  dist_vec_t      s2_f_q, s2_f_d;
  logic [3:0]     s2_wall_q, s2_wall_d;

  logic frame_done_q, frame_done_d;
  logic s1_load, s2_load, s2_can_load;
  dist_vec_t res;

`ifdef LBM_LID_CORR_EN
  localparam logic signed [DIST_W:0] CORR_X = LID_CORR;
`else
  logic unused_lid_corr;
  assign unused_lid_corr = ^LID_CORR;
`endif

  // Sources always read s1_f_q, so overlapping replacements never chain.
  always_comb begin
    res = s1_f_q;
    unique case (1'b1)
      s1_wall_q[WALL_BOTTOM]: begin
        res[D_PX]   = s1_f_q[OPP[D_PX]];
        res[D_PYPX] = s1_f_q[OPP[D_PYPX]];
        res[D_NYPX] = s1_f_q[OPP[D_NYPX]];
      end
      s1_wall_q[WALL_LEFT]: begin
        res[D_PY]   = s1_f_q[OPP[D_PY]];
        res[D_PYPX] = s1_f_q[OPP[D_PYPX]];
        res[D_PYNX] = s1_f_q[OPP[D_PYNX]];
      end
      s1_wall_q[WALL_RIGHT]: begin
        res[D_NY]   = s1_f_q[OPP[D_NY]];
        res[D_NYNX] = s1_f_q[OPP[D_NYNX]];
        res[D_NYPX] = s1_f_q[OPP[D_NYPX]];
      end
      s1_wall_q[WALL_LID]: begin
        res[D_NX] = s1_f_q[OPP[D_NX]];
`ifdef LBM_LID_CORR_EN
        res[D_NYNX] = sat_add(s1_f_q[OPP[D_NYNX]], -CORR_X);
        res[D_PYNX] = sat_add(s1_f_q[OPP[D_PYNX]], CORR_X);
`else
        res[D_NYNX] = s1_f_q[OPP[D_NYNX]];
        res[D_PYNX] = s1_f_q[OPP[D_PYNX]];
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    s2_can_load = !s2_valid_q || out_ready;
    in_ready    = !s1_valid_q || s2_can_load;
    s1_load     = in_valid && in_ready;
    s2_load     = s1_valid_q && s2_can_load;

    s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_x_d     = s1_load ? in_x   : s1_x_q;
    s1_y_d     = s1_load ? in_y   : s1_y_q;
    s1_f_d     = s1_load ? in_f   : s1_f_q;
    s1_wall_d  = s1_load ? wall_c : s1_wall_q;

    s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    s2_x_d     = s2_load ? s1_x_q    : s2_x_q;
    s2_y_d     = s2_load ? s1_y_q    : s2_y_q;
    s2_f_d     = s2_load ? res       : s2_f_q;
    s2_wall_d  = s2_load ? s1_wall_q : s2_wall_q;

    frame_done_d = s2_valid_q && out_ready &&
                   (s2_x_q == X_W'(LAST)) &&
                   (s2_y_q == Y_W'(LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_f_q       <= '0;
      s1_wall_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_f_q       <= '0;
      s2_wall_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_f_q       <= s1_f_d;
      s1_wall_q    <= s1_wall_d;
      s2_valid_q   <= s2_valid_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      s2_f_q       <= s2_f_d;
      s2_wall_q    <= s2_wall_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_x      = s2_x_q;
  assign out_y      = s2_y_q;
  assign out_f      = s2_f_q;
  assign out_wall   = s2_wall_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lbm_boundary_stage.sv
// Scoreboard bench for lbm_boundary_stage.
// Expected nodes are queued on acceptance and checked on output.
module tb_lbm_boundary_stage;
  import lbm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic [3:0] in_y = '0;
  dist_vec_t  in_f = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_x;
  logic [3:0] out_y;
  dist_vec_t  out_f;
  logic [3:0] out_wall;
  logic       frame_done;

  typedef struct packed {
    logic [7:0] x;
    logic [3:0] y;
    dist_vec_t  f;
    logic [3:0] wall;
  } node_t;

  node_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    fd_count = 0;
  bit    rand_mode = 1'b0;

  always #5 clk = ~clk;

  lbm_boundary_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_f       (in_f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_f      (out_f),
    .out_wall   (out_wall),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic dist_t clamp(input int v);
    if (v > 32767) return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return dist_t'(v);
  endfunction

  function automatic node_t model(input logic [7:0] x,
                                  input logic [3:0] y,
                                  input dist_vec_t f);
    node_t e;
    e.x = x;
    e.y = y;
    e.f = f;
    e.wall = 4'b0000;
    if (x == 0) begin
      e.wall = 4'b0100;
      e.f[2] = f[4]; e.f[5] = f[7]; e.f[6] = f[8];
    end else if (y == 0) begin
      e.wall = 4'b0010;
      e.f[1] = f[3]; e.f[5] = f[7]; e.f[8] = f[6];
    end else if (y == 15) begin
      e.wall = 4'b0001;
      e.f[3] = f[1]; e.f[7] = f[5]; e.f[6] = f[8];
    end else if (x == 15) begin
      e.wall = 4'b1000;
      e.f[4] = f[2];
`ifdef LBM_LID_CORR_EN
      e.f[7] = clamp(int'(f[5]) - 85);
      e.f[8] = clamp(int'(f[6]) + 85);
`else
      e.f[7] = f[5];
      e.f[8] = f[6];
`endif
    end
    return e;
  endfunction

  function automatic dist_vec_t rand_f();
    dist_vec_t f;
    for (int i = 0; i < 9; i++) f[i] = dist_t'($urandom);
    return f;
  endfunction

  always @(negedge clk)
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

  initial begin : monitor
    node_t e;
    node_t held;
    bit    stall;
    bit    fd_pend;
    stall = 0;
    fd_pend = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 0;
        fd_pend = 0;
      end else begin
        if (fd_pend || frame_done) begin
          chk("frame_done", 160'(frame_done), 160'(fd_pend));
          if (frame_done) fd_count++;
        end
        if (stall)
          chk("stall_hold", {out_x, out_y, out_f, out_wall}, held);
        fd_pend = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 160'(out_valid), 160'(0));
          end else begin
            e = q.pop_front();
            chk("out_node", {out_x, out_y, out_f, out_wall}, e);
          end
          fd_pend = (out_x == 15) && (out_y == 15);
        end
        stall = out_valid && !out_ready;
        held = {out_x, out_y, out_f, out_wall};
      end
    end
  end

  task automatic send(input logic [7:0] x,
                      input logic [3:0] y,
                      input dist_vec_t f);
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_f = f;
    for (int n = 0; n < 1000; n++) begin
      #1;
      if (in_ready) begin
        q.push_back(model(x, y, f));
        return;
      end
      @(negedge clk);
    end
    chk("in_ready_timeout", 160'(in_ready), 160'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    #3;
    chk("drain", 160'(q.size()), 160'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    dist_vec_t f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_out_data", {out_x, out_y, out_f, out_wall}, 160'(0));
    chk("rst_frame_done", 160'(frame_done), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) f[i] = dist_t'(i + 1);
    send(8'd5, 4'd7, f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("latency_s1", 160'(out_valid), 160'(0));
    @(posedge clk);
    #1;
    chk("latency_s2", 160'(out_valid), 160'(1));
    chk("interior_f", 160'(out_f), 160'(f));
    chk("interior_wall", 160'(out_wall), 160'(0));

    for (int i = 0; i < 9; i++) f[i] = dist_t'(i + 1);
    f[4] = 16'sd40; f[7] = 16'sd70; f[8] = 16'sd80;
    send(8'd0, 4'd7, f);
    for (int i = 0; i < 9; i++) f[i] = dist_t'(i + 1);
    f[2] = 16'sd20; f[5] = 16'sd500; f[6] = 16'sd600;
    send(8'd15, 4'd7, f);
    f[5] = -16'sd32760; f[6] = 16'sd32760;
    send(8'd15, 4'd3, f);
    send(8'd9, 4'd0, rand_f());
    send(8'd9, 4'd15, rand_f());
    idle();
    drain();

    rand_mode = 1'b1;
    for (int i = 0; i < 20; i++)
      send(8'($urandom_range(0, 14)), 4'($urandom_range(0, 15)), rand_f());
    idle();
    drain();
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        send(8'(x), 4'(y), rand_f());
    idle();
    drain();
    chk("frame_pulses", 160'(fd_count), 160'(1));

    for (int i = 0; i < 100; i++)
      send(8'(i / 16), 4'(i % 16), rand_f());
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 160'(out_valid), 160'(0));
    chk("midrst_in_ready", 160'(in_ready), 160'(1));
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #2;
      chk("post_rst_idle", 160'(out_valid), 160'(0));
    end
    chk("frame_pulses_end", 160'(fd_count), 160'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
